// File: rtl/spi_cfg_write_arbiter_if.sv
// Write-request bundle for the two requesters of spi_cfg_write_arbiter:
// port 0 is the SPI write path and port 1 is the auxiliary on-chip master.
interface spi_cfg_write_arbiter_if #(
   parameter int ADDR_W = 7,
   parameter int DATA_W = 8
);

   logic              req0_valid;
   logic              req0_ready;
   logic [ADDR_W-1:0] req0_addr;
   logic [DATA_W-1:0] req0_data;

   logic              req1_valid;
   logic              req1_ready;
   logic [ADDR_W-1:0] req1_addr;
   logic [DATA_W-1:0] req1_data;

   modport master (
      output req0_valid, req0_addr, req0_data,
      input  req0_ready,
      output req1_valid, req1_addr, req1_data,
      input  req1_ready
   );

   modport slave (
      input  req0_valid, req0_addr, req0_data,
      output req0_ready,
      input  req1_valid, req1_addr, req1_data,
      output req1_ready
   );

endinterface

// File: rtl/spi_cfg_write_arbiter.sv
// Owns the five PWM configuration registers and arbitrates writes from two ports.
// Optional macro CFG_ARB_ROUND_ROBIN_EN selects round-robin instead of fixed port-0 priority.
module spi_cfg_write_arbiter #(
   parameter int ADDR_W = 7,
   parameter int DATA_W = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   spi_cfg_write_arbiter_if.slave req,
   output logic [DATA_W-1:0]      en_reg_out_7_0,
   output logic [DATA_W-1:0]      en_reg_out_15_8,
   output logic [DATA_W-1:0]      en_reg_pwm_7_0,
   output logic [DATA_W-1:0]      en_reg_pwm_15_8,
   output logic [DATA_W-1:0]      pwm_duty_cycle,
   output logic                   wr_done,
   output logic                   wr_src,
   output logic [7:0]             bad_addr_cnt
);

   localparam logic [ADDR_W-1:0] ADDR_OUT_LO  = ADDR_W'(0);
   localparam logic [ADDR_W-1:0] ADDR_OUT_HI  = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] ADDR_PWM_LO  = ADDR_W'(2);
   localparam logic [ADDR_W-1:0] ADDR_PWM_HI  = ADDR_W'(3);
   localparam logic [ADDR_W-1:0] ADDR_DUTY    = ADDR_W'(4);

   typedef enum logic {
      IDLE,
      COMMIT
   } state_t;

   state_t            state;
   logic              hold_src;
   logic [ADDR_W-1:0] hold_addr;
   logic [DATA_W-1:0] hold_data;

   logic              grant_valid;
   logic              grant_port;

`ifdef CFG_ARB_ROUND_ROBIN_EN
   logic              last_grant;
`endif

   // Grant decision; only meaningful in IDLE, so COMMIT forces both readys low.
   always_comb begin
      // NOTE: every output gets a default first so no path through this block infers a latch.
      grant_valid = 1'b0;
      grant_port  = 1'b0;
      if (state == IDLE) begin
         if (req.req0_valid && req.req1_valid) begin
            grant_valid = 1'b1;
`ifdef CFG_ARB_ROUND_ROBIN_EN
            grant_port  = ~last_grant;
`else
            grant_port  = 1'b0;
`endif
         end else if (req.req0_valid) begin
            grant_valid = 1'b1;
            grant_port  = 1'b0;
         end else if (req.req1_valid) begin
            grant_valid = 1'b1;
            grant_port  = 1'b1;
         end
      end
   end

   assign req.req0_ready = grant_valid & ~grant_port;
   assign req.req1_ready = grant_valid &  grant_port;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: the config registers are individual flops, not a memory, so they are cleared here.
         state           <= IDLE;
         hold_src        <= 1'b0;
         hold_addr       <= '0;
         hold_data       <= '0;
         en_reg_out_7_0  <= '0;
         en_reg_out_15_8 <= '0;
         en_reg_pwm_7_0  <= '0;
         en_reg_pwm_15_8 <= '0;
         pwm_duty_cycle  <= '0;
         wr_done         <= 1'b0;
         wr_src          <= 1'b0;
         bad_addr_cnt    <= 8'h00;
`ifdef CFG_ARB_ROUND_ROBIN_EN
         last_grant      <= 1'b1;
`endif
      end else begin
         // NOTE: non-blocking assignments so every update here sees the pre-edge values.
         wr_done <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_valid) begin
                  hold_src  <= grant_port;
                  hold_addr <= grant_port ? req.req1_addr : req.req0_addr;
                  hold_data <= grant_port ? req.req1_data : req.req0_data;
`ifdef CFG_ARB_ROUND_ROBIN_EN
                  last_grant <= grant_port;
`endif
                  state     <= COMMIT;
               end
            end
            COMMIT: begin
               case (hold_addr)
                  ADDR_OUT_LO: en_reg_out_7_0  <= hold_data;
                  ADDR_OUT_HI: en_reg_out_15_8 <= hold_data;
                  ADDR_PWM_LO: en_reg_pwm_7_0  <= hold_data;
                  ADDR_PWM_HI: en_reg_pwm_15_8 <= hold_data;
                  ADDR_DUTY:   pwm_duty_cycle  <= hold_data;
                  default: begin
                     // Out-of-range address: drop the data, count it, never wrap.
                     if (bad_addr_cnt != 8'hFF) begin
                        bad_addr_cnt <= bad_addr_cnt + 8'd1;
                     end
                  end
               endcase
               wr_done <= 1'b1;
               wr_src  <= hold_src;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_cfg_write_arbiter.sv
// Self-checking bench for spi_cfg_write_arbiter: vector table, scoreboard queue and
// hand-written arbitration / reset corner sequences; follows CFG_ARB_ROUND_ROBIN_EN if defined.
module tb_spi_cfg_write_arbiter;

   localparam int ADDR_W = 7;
   localparam int DATA_W = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   spi_cfg_write_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   logic [7:0] r_out_lo, r_out_hi, r_pwm_lo, r_pwm_hi, r_duty, bad_cnt;
   logic       wr_done, wr_src;

   spi_cfg_write_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk             (clk),
      .rst             (rst),
      .req             (bus),
      .en_reg_out_7_0  (r_out_lo),
      .en_reg_out_15_8 (r_out_hi),
      .en_reg_pwm_7_0  (r_pwm_lo),
      .en_reg_pwm_15_8 (r_pwm_hi),
      .pwm_duty_cycle  (r_duty),
      .wr_done         (wr_done),
      .wr_src          (wr_src),
      .bad_addr_cnt    (bad_cnt)
   );

   typedef struct {
      bit         src;
      logic [6:0] addr;
      logic [7:0] data;
   } wr_t;

   typedef struct {
      bit         port;
      logic [6:0] addr;
      logic [7:0] data;
      logic [7:0] exp_val;
      logic [7:0] exp_bad;
   } vec_t;

   wr_t        exp_q[$];
   wr_t        mon_e;
   logic [7:0] m_regs [5];
   logic [7:0] m_bad;
   int         checks = 0;
   int         errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] dut_reg(input logic [6:0] addr);
      case (addr)
         7'h00:   return r_out_lo;
         7'h01:   return r_out_hi;
         7'h02:   return r_pwm_lo;
         7'h03:   return r_pwm_hi;
         default: return r_duty;
      endcase
   endfunction

   task automatic set_req(input bit port, input logic v, input logic [6:0] a, input logic [7:0] d);
      if (!port) begin
         bus.req0_valid = v;
         bus.req0_addr  = a;
         bus.req0_data  = d;
      end else begin
         bus.req1_valid = v;
         bus.req1_addr  = a;
         bus.req1_data  = d;
      end
   endtask

   function automatic logic get_ready(input bit port);
      return port ? bus.req1_ready : bus.req0_ready;
   endfunction

   // Called at a negedge; returns at the negedge right after the handshake edge.
   task automatic write_port(input bit port, input logic [6:0] a, input logic [7:0] d);
      bit done = 1'b0;
      set_req(port, 1'b1, a, d);
      for (int t = 0; t < 8 && !done; t++) begin
         #1;
         if (get_ready(port)) begin
            exp_q.push_back('{port, a, d});
            done = 1'b1;
         end
         @(negedge clk);
      end
      set_req(port, 1'b0, a, d);
      check("accept_timeout", 32'(done), 32'd1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      set_req(1'b0, 1'b0, 7'h00, 8'h00);
      set_req(1'b1, 1'b0, 7'h00, 8'h00);
      exp_q.delete();
      foreach (m_regs[i]) m_regs[i] = 8'h00;
      m_bad = 8'h00;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // Scoreboard: every wr_done pops one expected write and checks all outputs against the model.
   always @(negedge clk) begin
      #2;
      if (!rst) begin
         check("ready_exclusive", 32'(bus.req0_ready & bus.req1_ready), 32'd0);
         if (wr_done) begin
            if (exp_q.size() == 0) begin
               check("unexpected_wr_done", 32'd1, 32'd0);
            end else begin
               mon_e = exp_q.pop_front();
               if (mon_e.addr <= 7'h04) m_regs[mon_e.addr[2:0]] = mon_e.data;
               else if (m_bad != 8'hFF) m_bad = m_bad + 8'd1;
               check("sb_wr_src", 32'(wr_src), 32'(mon_e.src));
               for (int i = 0; i < 5; i++)
                  check($sformatf("sb_reg%0d", i), 32'(dut_reg(7'(i))), 32'(m_regs[i]));
               check("sb_bad_cnt", 32'(bad_cnt), 32'(m_bad));
            end
         end
      end
   end

   vec_t       vecs [11];
   logic [7:0] p0_left, p1_left;
   bit         in_commit, last, win, has;

   initial begin
      vecs[0]  = '{1'b0, 7'h04, 8'h80, 8'h80, 8'h00};
      vecs[1]  = '{1'b1, 7'h00, 8'h12, 8'h12, 8'h00};
      vecs[2]  = '{1'b0, 7'h01, 8'h34, 8'h34, 8'h00};
      vecs[3]  = '{1'b1, 7'h02, 8'hFF, 8'hFF, 8'h00};
      vecs[4]  = '{1'b0, 7'h03, 8'hC3, 8'hC3, 8'h00};
      vecs[5]  = '{1'b1, 7'h04, 8'h5A, 8'h5A, 8'h00};
      vecs[6]  = '{1'b0, 7'h05, 8'h99, 8'h00, 8'h01};
      vecs[7]  = '{1'b1, 7'h7F, 8'h11, 8'h00, 8'h02};
      vecs[8]  = '{1'b0, 7'h08, 8'hEE, 8'h00, 8'h03};
      vecs[9]  = '{1'b1, 7'h44, 8'hDD, 8'h00, 8'h04};
      vecs[10] = '{1'b0, 7'h02, 8'h3C, 8'h3C, 8'h04};

      // Reset state
      do_reset();
      #1;
      for (int i = 0; i < 5; i++) check($sformatf("rst_reg%0d", i), 32'(dut_reg(7'(i))), 32'd0);
      check("rst_bad_cnt", 32'(bad_cnt), 32'd0);
      check("rst_wr_done", 32'(wr_done), 32'd0);
      check("rst_wr_src", 32'(wr_src), 32'd0);
      check("rst_ready0", 32'(bus.req0_ready), 32'd0);
      check("rst_ready1", 32'(bus.req1_ready), 32'd0);

      // Table: single writes, result visible one clock after the handshake edge
      foreach (vecs[i]) begin
         write_port(vecs[i].port, vecs[i].addr, vecs[i].data);
         @(negedge clk);
         #1;
         check("vec_wr_done", 32'(wr_done), 32'd1);
         if (vecs[i].addr <= 7'h04)
            check("vec_reg", 32'(dut_reg(vecs[i].addr)), 32'(vecs[i].exp_val));
         check("vec_bad_cnt", 32'(bad_cnt), 32'(vecs[i].exp_bad));
      end

      // Simultaneous requests: port 0 first, port 1 accepted once after COMMIT
      @(negedge clk);
      do_reset();
      set_req(1'b0, 1'b1, 7'h00, 8'hAA);
      set_req(1'b1, 1'b1, 7'h01, 8'h55);
      #1;
      check("both_ready0", 32'(bus.req0_ready), 32'd1);
      check("both_ready1", 32'(bus.req1_ready), 32'd0);
      exp_q.push_back('{1'b0, 7'h00, 8'hAA});
      @(negedge clk);
      set_req(1'b0, 1'b0, 7'h00, 8'hAA);
      #1;
      check("commit_ready0", 32'(bus.req0_ready), 32'd0);
      check("commit_ready1", 32'(bus.req1_ready), 32'd0);
      @(negedge clk);
      #1;
      check("both_done_p0", 32'(wr_done), 32'd1);
      check("both_ready1_after", 32'(bus.req1_ready), 32'd1);
      exp_q.push_back('{1'b1, 7'h01, 8'h55});
      @(negedge clk);
      set_req(1'b1, 1'b0, 7'h01, 8'h55);
      #1;
      check("both_done_gap", 32'(wr_done), 32'd0);
      @(negedge clk);
      #1;
      check("both_done_p1", 32'(wr_done), 32'd1);
      check("both_reg0", 32'(r_out_lo), 32'hAA);
      check("both_reg1", 32'(r_out_hi), 32'h55);

      // Port 0 held valid for 6 writes while port 1 waits with one write
      @(negedge clk);
      do_reset();
      p0_left   = 8'd6;
      p1_left   = 8'd1;
      in_commit = 1'b0;
      last      = 1'b1;
      for (int cyc = 0; cyc < 40 && (p0_left != 0 || p1_left != 0 || in_commit); cyc++) begin
         set_req(1'b0, p0_left != 0, 7'h04, 8'h10 + p0_left);
         set_req(1'b1, p1_left != 0, 7'h03, 8'h77);
         #1;
         if (in_commit) begin
            check("arb_commit_ready0", 32'(bus.req0_ready), 32'd0);
            check("arb_commit_ready1", 32'(bus.req1_ready), 32'd0);
            in_commit = 1'b0;
         end else begin
            has = (p0_left != 0) || (p1_left != 0);
            if (p0_left != 0 && p1_left != 0) begin
`ifdef CFG_ARB_ROUND_ROBIN_EN
               win = ~last;
`else
               win = 1'b0;
`endif
            end else begin
               win = (p0_left == 0);
            end
            check("arb_ready0", 32'(bus.req0_ready), 32'(has && !win));
            check("arb_ready1", 32'(bus.req1_ready), 32'(has && win));
            if (has) begin
               if (win) begin
                  exp_q.push_back('{1'b1, 7'h03, 8'h77});
                  p1_left = p1_left - 8'd1;
               end else begin
                  exp_q.push_back('{1'b0, 7'h04, 8'h10 + p0_left});
                  p0_left = p0_left - 8'd1;
               end
               last      = win;
               in_commit = 1'b1;
            end
         end
         @(negedge clk);
      end
      set_req(1'b0, 1'b0, 7'h00, 8'h00);
      set_req(1'b1, 1'b0, 7'h00, 8'h00);
      check("arb_all_served", 32'(p0_left) + 32'(p1_left), 32'd0);
      @(negedge clk);

      // Invalid addresses: counter saturates at 0xFF
      for (int i = 0; i < 260; i++) begin
         write_port(i[0], 7'(5 + (i % 123)), 8'(i));
         @(negedge clk);
      end
      #1;
      check("bad_saturated", 32'(bad_cnt), 32'hFF);

      // Reset during COMMIT discards the pending write
      @(negedge clk);
      write_port(1'b0, 7'h02, 8'h3C);
      @(negedge clk);
      set_req(1'b0, 1'b1, 7'h02, 8'hFF);
      #1;
      check("abort_ready0", 32'(bus.req0_ready), 32'd1);
      @(negedge clk);
      set_req(1'b0, 1'b0, 7'h02, 8'hFF);
      rst = 1'b1;
      exp_q.delete();
      foreach (m_regs[i]) m_regs[i] = 8'h00;
      m_bad = 8'h00;
      #1;
      check("abort_pwm_lo", 32'(r_pwm_lo), 32'd0);
      check("abort_wr_done", 32'(wr_done), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("abort_no_done", 32'(wr_done), 32'd0);
      check("abort_bad_clr", 32'(bad_cnt), 32'd0);
      set_req(1'b1, 1'b1, 7'h03, 8'h21);
      #1;
      check("abort_idle_ready1", 32'(bus.req1_ready), 32'd1);
      exp_q.push_back('{1'b1, 7'h03, 8'h21});
      @(negedge clk);
      set_req(1'b1, 1'b0, 7'h03, 8'h21);
      @(negedge clk);
      #1;
      check("abort_next_done", 32'(wr_done), 32'd1);
      check("abort_next_pwm_lo", 32'(r_pwm_lo), 32'd0);

      repeat (3) @(negedge clk);
      check("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
